// File: rtl/mist1032isa_uart_pkg.sv
// Shared definitions for the mist1032isa UART receive path:
// parity modes, RX FSM state encodings and the FIFO entry width.
package mist1032isa_uart_pkg;

  localparam logic [1:0] UART_PARITY_NONE = 2'd0;
  localparam logic [1:0] UART_PARITY_EVEN = 2'd1;
  localparam logic [1:0] UART_PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_BREAKWAIT
  } rx_state_e;

  // {overrun, frame_err, parity_err, data}
  function automatic int unsigned rx_entry_width(
    input int unsigned data_bits
  );
    return data_bits + 3;
  endfunction

endpackage

// File: rtl/mist1032isa_uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: push_i/wdata_i/full_o write side, pop_i/valid_o/rdata_o read side.
module mist1032isa_uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign valid_o = (wptr_q != rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop frees the slot the push lands in when full.
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata_i;
      wptr_d = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/mist1032isa_uart_receiver_ex.sv
// UART receiver in the iCLOCK domain: baud tick, majority vote, FSM, FIFO.
// Ports: iUART_RXD in; oRX_* head entry out with iRX_READY handshake.
module mist1032isa_uart_receiver_ex
  import mist1032isa_uart_pkg::*;
#(
  parameter int          DATA_BITS        = 8,
  parameter int          OVERSAMPLE       = 16,
  parameter logic        BAUDRATE_FIXED   = 1'b1,
  parameter logic [19:0] BAUDRATE_COUNTER = 20'd26,
  parameter int          FIFO_DEPTH       = 4
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic [19:0]          iEXTBAUD_COUNT,
  input  logic [1:0]           iPARITY_MODE,
  input  logic                 iSTOP_BITS,
  output logic                 oRX_VALID,
  input  logic                 iRX_READY,
  output logic [DATA_BITS-1:0] oRX_DATA,
  output logic                 oRX_PARITY_ERR,
  output logic                 oRX_FRAME_ERR,
  output logic                 oRX_OVERRUN,
  input  logic                 iUART_RXD
);

  localparam int EW  = rx_entry_width(DATA_BITS);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] SMP0 = OSW'(OVERSAMPLE/2 - 1);
  localparam logic [OSW-1:0] SMP1 = OSW'(OVERSAMPLE/2);
  localparam logic [OSW-1:0] SMP2 = OSW'(OVERSAMPLE/2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [19:0]          baud_cnt_q, baud_cnt_d;
  logic [19:0]          div_q, div_d;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic [19:0]   div_live, div_cur;
  logic          tick, dec, bit_val, start_edge, par_en;
  logic          push, fifo_full, fifo_pop;
  logic [EW-1:0] push_data, head;

  assign div_live   = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;
  assign start_edge = rxd_prev_q & ~rxd_s2_q;
  assign par_en     = (pmode_q == UART_PARITY_EVEN) ||
                      (pmode_q == UART_PARITY_ODD);
  // Third vote comes straight from the line on the deciding tick.
  assign bit_val    = (smp_q[0] & smp_q[1]) |
                      (smp_q[0] & rxd_s2_q) |
                      (smp_q[1] & rxd_s2_q);
  assign fifo_pop   = oRX_VALID & iRX_READY;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    smp_d      = smp_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    push       = 1'b0;
    push_data  = '0;

    div_cur    = (state_q == RX_IDLE) ? div_live : div_q;
    tick       = (baud_cnt_q == div_cur);
    baud_cnt_d = tick ? '0 : baud_cnt_q + 20'd1;
    os_cnt_d   = os_cnt_q;
    if (tick) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
      if (os_cnt_q == SMP0) smp_d[0] = rxd_s2_q;
      if (os_cnt_q == SMP1) smp_d[1] = rxd_s2_q;
    end
    dec = tick && (os_cnt_q == SMP2);

    unique case (state_q)
      RX_IDLE: begin
        if (start_edge) begin
          state_d    = RX_START;
          baud_cnt_d = '0;
          os_cnt_d   = '0;
          div_d      = div_live;
          pmode_d    = iPARITY_MODE;
          stop2_d    = iSTOP_BITS;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (dec) state_d = bit_val ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (dec) begin
          data_d    = {bit_val, data_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BC_LAST) begin
            state_d = par_en ? RX_PARITY : RX_STOP1;
          end
        end
      end
      RX_PARITY: begin
        if (dec) begin
          perr_d  = ((^data_q) ^ bit_val) !=
                    (pmode_q == UART_PARITY_ODD);
          state_d = RX_STOP1;
        end
      end
      RX_STOP1, RX_STOP2: begin
        if (dec) begin
          ferr_d = ferr_q | ~bit_val;
          if (state_q == RX_STOP1 && stop2_q) begin
            state_d = RX_STOP2;
          end else begin
            push      = 1'b1;
            push_data = {ovr_q, ferr_d, perr_q, data_q};
            // Re-arm mid-bit so the next start edge is never missed.
            state_d   = bit_val ? RX_IDLE : RX_BREAKWAIT;
          end
        end
      end
      RX_BREAKWAIT: begin
        if (rxd_s2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (push) ovr_d = fifo_full & ~fifo_pop;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= RX_IDLE;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      baud_cnt_q <= '0;
      div_q      <= '0;
      os_cnt_q   <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      pmode_q    <= UART_PARITY_NONE;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_s1_q   <= iUART_RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      os_cnt_q   <= os_cnt_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  mist1032isa_uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (iCLOCK),
    .rst_n   (inRESET),
    .push_i  (push),
    .wdata_i (push_data),
    .full_o  (fifo_full),
    .pop_i   (iRX_READY),
    .valid_o (oRX_VALID),
    .rdata_o (head)
  );

  assign {oRX_OVERRUN, oRX_FRAME_ERR, oRX_PARITY_ERR, oRX_DATA} = head;

endmodule

// File: tb/tb_mist1032isa_uart_receiver_ex.sv
// Bench for mist1032isa_uart_receiver_ex: frame table plus corner sequences,
// received entries checked against a queue of expected characters.
module tb_mist1032isa_uart_receiver_ex;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] ext_div;
  logic [1:0]  pmode;
  logic        stop2;
  logic        rdy;
  logic        rxd;
  logic        vld;
  logic [7:0]  dat;
  logic        perr, ferr, ovr;

  always #5 clk = ~clk;

  mist1032isa_uart_receiver_ex #(
    .DATA_BITS        (8),
    .OVERSAMPLE       (OS),
    .BAUDRATE_FIXED   (1'b0),
    .BAUDRATE_COUNTER (20'd1),
    .FIFO_DEPTH       (4)
  ) dut (
    .iCLOCK         (clk),
    .inRESET        (rst_n),
    .iEXTBAUD_COUNT (ext_div),
    .iPARITY_MODE   (pmode),
    .iSTOP_BITS     (stop2),
    .oRX_VALID      (vld),
    .iRX_READY      (rdy),
    .oRX_DATA       (dat),
    .oRX_PARITY_ERR (perr),
    .oRX_FRAME_ERR  (ferr),
    .oRX_OVERRUN    (ovr),
    .iUART_RXD      (rxd)
  );

  typedef struct packed {
    logic       ovr;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       two;
    logic       pb;
    logic       s1;
    logic       s2;
    logic       perr;
    logic       ferr;
  } vec_t;

  ent_t sb_q[$];
  vec_t tbl[8];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bitc();
    return OS * (int'(ext_div) + 1);
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    rxd = b;
    repeat (bitc() - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
                            input logic two, input logic pb,
                            input logic s1, input logic s2);
    pmode = pm;
    stop2 = two;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pm == 2'd1 || pm == 2'd2) send_bit(pb);
    send_bit(s1);
    if (two) send_bit(s2);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send8n1(input logic [7:0] d);
    send_frame(d, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic expect_ent(input logic o, input logic f,
                            input logic p, input logic [7:0] d);
    ent_t e;
    e = '{ovr: o, ferr: f, perr: p, data: d};
    sb_q.push_back(e);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rdy = v;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d entries outstanding, required 0",
               nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    tbl[0] = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h96, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'hC8, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n   = 1'b0;
    ext_div = 20'd1;
    pmode   = 2'd0;
    stop2   = 1'b0;
    rdy     = 1'b0;
    rxd     = 1'b1;

    fork
      forever begin
        ent_t e;
        @(negedge clk);
        if (vld && rdy) begin
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected entry: got %0h required none",
                     {ovr, ferr, perr, dat});
          end else begin
            e = sb_q.pop_front();
            chk("rx entry", {21'd0, ovr, ferr, perr, dat}, {21'd0, e});
          end
        end
      end
    join_none

    #1;
    chk("reset valid", vld, 0);
    chk("reset head", {ovr, ferr, perr, dat}, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0x55 with ready low: push lands 22 clocks into the stop bit.
    expect_ent(1'b0, 1'b0, 1'b0, 8'h55);
    pmode = 2'd0;
    stop2 = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(tbl[0].d[i]);
    @(negedge clk);
    rxd = 1'b1;
    repeat (22) @(negedge clk);
    chk("valid before push", vld, 0);
    @(negedge clk);
    chk("valid after push", vld, 1);
    chk("head data", dat, 8'h55);
    repeat (8) @(negedge clk);
    send_bit(1'b1);
    set_ready(1'b1);
    wait_empty("first char");

    for (int v = 1; v < 8; v++) begin
      expect_ent(1'b0, tbl[v].ferr, tbl[v].perr, tbl[v].d);
      send_frame(tbl[v].d, tbl[v].pm, tbl[v].two, tbl[v].pb,
                 tbl[v].s1, tbl[v].s2);
    end
    wait_empty("table");

    // Short low glitch is a false start.
    @(negedge clk);
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * bitc()) @(negedge clk);
    chk("glitch no entry", vld, 0);
    expect_ent(1'b0, 1'b0, 1'b0, 8'h3C);
    send8n1(8'h3C);
    wait_empty("after glitch");

    // Bad second stop, then a 40-bit break.
    expect_ent(1'b0, 1'b1, 1'b0, 8'hF0);
    send_frame(8'hF0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_ent(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rxd = 1'b0;
    repeat (40 * bitc()) @(negedge clk);
    wait_empty("break");
    chk("break one entry", vld, 0);
    rxd = 1'b1;
    repeat (2 * bitc()) @(negedge clk);
    chk("break release", vld, 0);
    expect_ent(1'b0, 1'b0, 1'b0, 8'h5A);
    send8n1(8'h5A);
    wait_empty("after break");

    // Overrun: six characters into a four-deep FIFO.
    set_ready(1'b0);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) expect_ent(1'b0, 1'b0, 1'b0, 8'(i));
      send8n1(8'(i));
    end
    chk("full head valid", vld, 1);
    chk("full head data", dat, 8'h01);
    chk("full head overrun", ovr, 0);
    set_ready(1'b1);
    wait_empty("drain");
    expect_ent(1'b1, 1'b0, 1'b0, 8'h07);
    send8n1(8'h07);
    expect_ent(1'b0, 1'b0, 1'b0, 8'h08);
    send8n1(8'h08);
    wait_empty("overrun");

    // Reset in the middle of a character.
    set_ready(1'b0);
    expect_ent(1'b0, 1'b0, 1'b0, 8'h11);
    send8n1(8'h11);
    chk("pre-reset valid", vld, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset async valid", vld, 0);
    sb_q.delete();
    rxd = 1'b1;
    repeat (3 * bitc()) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    expect_ent(1'b0, 1'b0, 1'b0, 8'h81);
    send8n1(8'h81);
    wait_empty("after reset");

    // Slower runtime divisor.
    ext_div = 20'd3;
    repeat (8) @(negedge clk);
    expect_ent(1'b0, 1'b0, 1'b0, 8'h81);
    send8n1(8'h81);
    expect_ent(1'b0, 1'b0, 1'b1, 8'h07);
    send_frame(8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_empty("ext divisor");

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
